systolic_tile_mac: RTL
======================

// Module: systolic_tile_mac
// PURPOSE
//  Parametrised SA_W x SA_W output-stationary systolic MAC tile for the Frodo matrix unit.
//  Computes C = A*B + BIAS mod 2^SUM_W over a run-time depth k_len.
//  Operand skew is internal, so no external transposers are needed. B can be full-width
//  or packed SAMPLE_W-bit (S/E matrix) samples, zero- or sign-extended.
//  Rows drain on a valid/ready stream toward the BRAM write-back path.
// PARAMETERS
//  SA_W      4   array rows = cols = lanes per beat
//  DATA_W    16  operand element width
//  SUM_W     16  accumulator/output width (Frodo q = 2^16)
//  SAMPLE_W  8   packed-B sample width; DATA_W % SAMPLE_W == 0, DATA_W >= 2*SAMPLE_W
//  K_W       16  width of k_len
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  async active-high reset
//  start      in   1                  1-cycle pulse; latches k_len/b_packed/b_signed/b_grp/bias_en, clears accs
//  k_len      in   K_W                number of A/B beats (0 allowed)
//  b_packed   in   1                  1: B lanes taken from SAMPLE_W group b_grp
//  b_signed   in   1                  1: packed samples sign-extended, 0: zero-extended
//  b_grp      in   $clog2(DATA_W*SA_W/(SAMPLE_W*SA_W))  packed group select (DATA_W/SAMPLE_W groups)
//  bias_en    in   1                  1: add bias_data to each drained row
//  in_valid   in   1                  A/B beat valid
//  in_ready   out  1                  high only in LOAD
//  a_data     in   SA_W*DATA_W        lane i = A[i][k]
//  b_data     in   SA_W*DATA_W        lane j = B[k][j] (or packed bytes)
//  bias_data  in   SA_W*SUM_W         bias row, sampled when out_valid&&out_ready
//  out_valid  out  1                  result row valid
//  out_ready  in   1                  consumer accepts row
//  out_data   out  SA_W*SUM_W         lane j = C[out_row][j] (+bias)
//  out_row    out  $clog2(SA_W)       row index of out_data
//  busy       out  1                  state != IDLE
//  done       out  1                  1-cycle pulse after last row accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accs/skew regs/counters 0. Effective immediately, even mid-op.
//  FSM: IDLE -start-> LOAD (or FLUSH if k_len==0) -k_len beats-> FLUSH
//       -(2*SA_W-1) cycles-> DRAIN -SA_W rows accepted-> IDLE (+done).
//  start while busy: ignored; config inputs are read only on accepted start.
//  LOAD: beat consumed on in_valid&&in_ready. Beat counter stops at k_len;
//        in_ready drops the cycle after the last beat.
//  Bubbles (no handshake in LOAD, and all FLUSH cycles) inject zeros into both skews.
//  Skew: a lane i delayed i cycles, b lane j delayed j cycles. PE(i,j) forwards a right, b down
//        (1-cycle reg each) and does acc += a*b.
//  Product: full DATA_W x DATA_W product, then truncated to low SUM_W bits; acc wraps mod 2^SUM_W.
//  Packed B: lane j = ext(b_data[(g*SA_W+j)*SAMPLE_W +: SAMPLE_W]), g = b_grp.
//    Example (SA_W=4, SAMPLE_W=8): g=0 -> bytes 0..3, g=1 -> bytes 4..7.
//  DRAIN: out_valid=1, out_row counts 0..SA_W-1.
//    out_data = acc row (+bias_data if bias_en), all sums mod 2^SUM_W.
//    Held stable while out_valid&&!out_ready; row advances only on handshake.
//  done: asserted the cycle after the final row handshake. busy falls with done.
//  Accs are cleared on start only. Rows stay valid until drained, so no row is dropped under backpressure.
// TESTING (SA_W=4, DATA_W=SUM_W=16, SAMPLE_W=8)
//  A=I, k_len=4, B rows {1,2,3,4}x(row+1), bias off -> out rows 1,2,3,4 lanes {1,2,3,4}*(r+1).
//  Packed: a all 1, k_len=1, b_data=0x0807060504030201, grp1 unsigned -> every row {5,6,7,8}.
//    Same with grp0 -> every row {1,2,3,4}.
//  Signed: grp0 byte0=0xFF, b_signed=1, a=1 -> lane0 0xFFFF; with b_signed=0 -> lane0 0x00FF.
//  Wrap: a=0x8000,b=2 -> 0x0000; a=b=0xFFFF -> 0x0001; bias 0xFFFF + acc 2 -> 0x0001.
//  Stalls: in_valid toggled 1-0-1, out_ready low 3 cycles per row
//    -> results equal unstalled run; out_data stable while stalled.
//  Edge: k_len=0, bias_en=1 -> rows equal bias, done after 4 handshakes.
//    rst mid-LOAD -> all outputs 0; next start gives correct result.
//    start while busy -> no effect.

Source files
------------

// File: rtl/systolic_tile_mac.sv
// Output-stationary SA_W x SA_W systolic MAC tile: C = A*B (+bias) mod 2^SUM_W over k_len beats,
// with internal operand skew, packed-B sample unpacking and a valid/ready row drain.
module systolic_tile_mac #(
  parameter int SA_W     = 4,
  parameter int DATA_W   = 16,
  parameter int SUM_W    = 16,
  parameter int SAMPLE_W = 8,
  parameter int K_W      = 16,
  localparam int GRP_W   = $clog2(DATA_W / SAMPLE_W),
  localparam int ROW_W   = $clog2(SA_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  input  logic                   b_packed,
  input  logic                   b_signed,
  input  logic [GRP_W-1:0]       b_grp,
  input  logic                   bias_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SA_W*DATA_W-1:0] a_data,
  input  logic [SA_W*DATA_W-1:0] b_data,
  input  logic [SA_W*SUM_W-1:0]  bias_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SA_W*SUM_W-1:0]  out_data,
  output logic [ROW_W-1:0]       out_row,
  output logic                   busy,
  output logic                   done
);
  localparam int FL_W = $clog2(2 * SA_W);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(2 * SA_W - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t              r_state;
  logic [K_W-1:0]      r_kLen;
  logic [K_W-1:0]      r_beatCnt;
  logic [FL_W-1:0]     r_flushCnt;
  logic [GRP_W-1:0]    r_bGrp;
  logic                r_bPacked;
  logic                r_bSigned;
  logic                r_biasEn;
  logic                r_inReady;
  logic                r_outValid;
  logic                r_busy;
  logic                r_done;
  logic [ROW_W-1:0]    r_outRow;

  logic [DATA_W-1:0]   r_aPe  [SA_W][SA_W-1];
  logic [DATA_W-1:0]   r_bPe  [SA_W-1][SA_W];
  logic [SUM_W-1:0]    r_acc  [SA_W][SA_W];

  logic                w_fire;
  logic                w_clear;
  logic [SAMPLE_W-1:0] w_sample [SA_W];
  logic [DATA_W-1:0]   w_aIn    [SA_W];
  logic [DATA_W-1:0]   w_bIn    [SA_W];
  logic [DATA_W-1:0]   w_aEdge  [SA_W];
  logic [DATA_W-1:0]   w_bEdge  [SA_W];
  logic [DATA_W-1:0]   w_peA    [SA_W][SA_W];
  logic [DATA_W-1:0]   w_peB    [SA_W][SA_W];
  logic [SUM_W-1:0]    w_outLane [SA_W];

  assign w_fire  = r_inReady & in_valid;
  assign w_clear = (r_state == IDLE) & start;

  function automatic logic [SUM_W-1:0] mulTrunc(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return SUM_W'({{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b});
  endfunction

  // Anything other than an accepted beat enters the array as a zero bubble.
  always_comb begin
    for (int j = 0; j < SA_W; j++) begin
      w_sample[j] = b_data[(int'(r_bGrp) * SA_W + j) * SAMPLE_W +: SAMPLE_W];
      w_aIn[j]    = w_fire ? a_data[j*DATA_W +: DATA_W] : '0;
      if (!w_fire)
        w_bIn[j] = '0;
      else if (r_bPacked)
        w_bIn[j] = {{(DATA_W-SAMPLE_W){r_bSigned & w_sample[j][SAMPLE_W-1]}}, w_sample[j]};
      else
        w_bIn[j] = b_data[j*DATA_W +: DATA_W];
    end
  end

  // Lane i sits behind i+1 registers so PE(i,j) sees beat k at the same time from both sides.
  for (genvar i = 0; i < SA_W; i++) begin : g_skew
    logic [DATA_W-1:0] r_aDly [i+1];
    logic [DATA_W-1:0] r_bDly [i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= i; d++) begin
          r_aDly[d] <= '0;
          r_bDly[d] <= '0;
        end
      end else if (w_clear) begin
        for (int d = 0; d <= i; d++) begin
          r_aDly[d] <= '0;
          r_bDly[d] <= '0;
        end
      end else begin
        r_aDly[0] <= w_aIn[i];
        r_bDly[0] <= w_bIn[i];
        for (int d = 1; d <= i; d++) begin
          r_aDly[d] <= r_aDly[d-1];
          r_bDly[d] <= r_bDly[d-1];
        end
      end
    end

    assign w_aEdge[i] = r_aDly[i];
    assign w_bEdge[i] = r_bDly[i];
  end

  always_comb begin
    for (int i = 0; i < SA_W; i++) begin
      w_peA[i][0] = w_aEdge[i];
      for (int j = 1; j < SA_W; j++) w_peA[i][j] = r_aPe[i][j-1];
    end
    for (int j = 0; j < SA_W; j++) begin
      w_peB[0][j] = w_bEdge[j];
      for (int i = 1; i < SA_W; i++) w_peB[i][j] = r_bPe[i-1][j];
    end
  end

  // PE grid: a moves right, b moves down, every PE accumulates its product in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clear) begin
      for (int i = 0; i < SA_W; i++)
        for (int j = 0; j < SA_W; j++) r_acc[i][j] <= '0;
      for (int i = 0; i < SA_W; i++)
        for (int j = 0; j < SA_W-1; j++) r_aPe[i][j] <= '0;
      for (int i = 0; i < SA_W-1; i++)
        for (int j = 0; j < SA_W; j++) r_bPe[i][j] <= '0;
    end else begin
      for (int i = 0; i < SA_W; i++)
        for (int j = 0; j < SA_W; j++)
          r_acc[i][j] <= r_acc[i][j] + mulTrunc(w_peA[i][j], w_peB[i][j]);
      for (int i = 0; i < SA_W; i++)
        for (int j = 0; j < SA_W-1; j++) r_aPe[i][j] <= w_peA[i][j];
      for (int i = 0; i < SA_W-1; i++)
        for (int j = 0; j < SA_W; j++) r_bPe[i][j] <= w_peB[i][j];
    end
  end

  // FLUSH lasts long enough for the last beat to reach the far corner PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kLen     <= '0;
      r_beatCnt  <= '0;
      r_flushCnt <= '0;
      r_bGrp     <= '0;
      r_bPacked  <= 1'b0;
      r_bSigned  <= 1'b0;
      r_biasEn   <= 1'b0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_outRow   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kLen     <= k_len;
            r_bPacked  <= b_packed;
            r_bSigned  <= b_signed;
            r_bGrp     <= b_grp;
            r_biasEn   <= bias_en;
            r_beatCnt  <= '0;
            r_flushCnt <= '0;
            r_busy     <= 1'b1;
            if (k_len == '0) begin
              r_state <= FLUSH;
            end else begin
              r_state   <= LOAD;
              r_inReady <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_fire) begin
            r_beatCnt <= r_beatCnt + K_W'(1);
            if (r_beatCnt == r_kLen - K_W'(1)) begin
              r_inReady <= 1'b0;
              r_state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (r_flushCnt == FL_LAST) begin
            r_state    <= DRAIN;
            r_outValid <= 1'b1;
            r_outRow   <= '0;
          end else begin
            r_flushCnt <= r_flushCnt + FL_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_outRow == ROW_LAST) begin
              r_state    <= IDLE;
              r_outValid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_outRow   <= '0;
            end else begin
              r_outRow <= r_outRow + ROW_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bias joins the row combinationally so it is the value present at the handshake.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < SA_W; j++) begin
      w_outLane[j] = r_acc[r_outRow][j] + (r_biasEn ? bias_data[j*SUM_W +: SUM_W] : '0);
      out_data[j*SUM_W +: SUM_W] = r_outValid ? w_outLane[j] : '0;
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_row   = r_outRow;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
